// File: rtl/window_accum.sv
// Window reducer: sum / signed max / signed min over back-to-back windows of P samples.
// Latency: one registered result per window, valid the cycle after the closing sample.
// Backpressure: none; one sample is consumed on every ACCUM cycle.
module window_accum #(
  parameter int DATA_W   = 32,
  parameter int PERIOD_W = 10,
  parameter int DELAY_W  = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                running,
  input  logic [DATA_W-1:0]   in0,
  output logic [DATA_W-1:0]   out0,
  output logic                valid,
  output logic                done,
  input  logic [PERIOD_W-1:0] period,
  input  logic [DELAY_W-1:0]  delay,
  input  logic [1:0]          mode
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ACCUM = 2'd2
  } state_t;

  localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);
  localparam logic [DELAY_W-1:0]  D_ONE = DELAY_W'(1);

  state_t              state, state_nxt;
  logic [PERIOD_W-1:0] p_lat;
  logic [1:0]          m_lat;
  logic [PERIOD_W-1:0] cnt;
  logic [DELAY_W-1:0]  dcnt;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   reduced;
  logic [DATA_W-1:0]   combined;
  logic                start;
  logic                in_accum;
  logic                close;

  assign start    = run & running;
  assign in_accum = (state == S_ACCUM);
  assign close    = in_accum && (cnt == p_lat - P_ONE);
  assign done     = (state != S_WAIT);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_IDLE;
      S_WAIT:  if (dcnt == D_ONE) state_nxt = S_ACCUM;
      S_ACCUM: state_nxt = S_ACCUM;
      default: state_nxt = S_IDLE;
    endcase
    // A run accepted in any state (re)starts the sequence with the incoming delay.
    if (start) state_nxt = (delay != '0) ? S_WAIT : S_ACCUM;
    if (!running) state_nxt = S_IDLE;
  end

  always_comb begin
    reduced = acc + in0;
    case (m_lat)
      2'd1:    reduced = ($signed(in0) > $signed(acc)) ? in0 : acc;
      2'd2:    reduced = ($signed(in0) < $signed(acc)) ? in0 : acc;
      default: reduced = acc + in0;
    endcase
    // First sample of a window replaces the stale accumulator outright.
    combined = (cnt == '0) ? in0 : reduced;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      out0  <= '0;
      valid <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      dcnt  <= '0;
      p_lat <= P_ONE;
      m_lat <= 2'd0;
    end else begin
      state <= state_nxt;
      valid <= close;
      if (close) out0 <= combined;

      if (start) begin
        p_lat <= (period == '0) ? P_ONE : period;
        m_lat <= mode;
        dcnt  <= delay;
      end else if (state == S_WAIT) begin
        dcnt <= dcnt - D_ONE;
      end

      // Restart or abort discards any partial window.
      if (start || !running) begin
        acc <= '0;
        cnt <= '0;
      end else if (in_accum) begin
        if (close) begin
          cnt <= '0;
        end else begin
          acc <= combined;
          cnt <= cnt + P_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_accum.sv
// Directed bench for window_accum: inputs driven and outputs checked on the falling edge.
module tb_window_accum;

  logic        clk = 1'b0;
  logic        rst, run, running;
  logic [31:0] in0, out0;
  logic        valid, done;
  logic [9:0]  period;
  logic [6:0]  delay;
  logic [1:0]  mode;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  window_accum #(.DATA_W(32), .PERIOD_W(10), .DELAY_W(7)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .running (running),
    .in0     (in0),
    .out0    (out0),
    .valid   (valid),
    .done    (done),
    .period  (period),
    .delay   (delay),
    .mode    (mode)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Cycle t0: accepted run with the given config.
  task automatic start(input int p, input int d, input int m);
    @(negedge clk);
    run     = 1'b1;
    running = 1'b1;
    period  = p[9:0];
    delay   = d[6:0];
    mode    = m[1:0];
  endtask

  task automatic go_idle();
    @(negedge clk);
    run     = 1'b0;
    running = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] mm_vals [3];

  initial begin
    rst = 1'b1; run = 1'b0; running = 1'b0; in0 = '0;
    period = '0; delay = '0; mode = '0;
    mm_vals[0] = 32'hFFFF_FFFB;
    mm_vals[1] = 32'd7;
    mm_vals[2] = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    chk("rst_out0", out0, 32'd0);
    chk("rst_valid", valid, 0);
    chk("rst_done", done, 1);
    rst = 1'b0;

    // Sum, period 4; a mid-run period change must be ignored.
    start(4, 0, 0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk("sum_valid", valid, (c == 5 || c == 9) ? 1 : 0);
      if (c == 5) chk("sum_w0", out0, 32'd10);
      if (c == 9) chk("sum_w1", out0, 32'd26);
      run    = 1'b0;
      period = 10'd7;
      in0    = c;
    end
    go_idle();

    // Start delay 3, period 2, constant 5.
    start(2, 3, 0);
    chk("dly_done_t0", done, 1);
    in0 = 32'd5;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("dly_done", done, (c >= 1 && c <= 3) ? 0 : 1);
      chk("dly_valid", valid, (c == 6) ? 1 : 0);
      if (c == 6) chk("dly_out0", out0, 32'd10);
      run = 1'b0;
    end
    go_idle();

    // Signed max then signed min over -5, 7, -1.
    for (int m = 1; m <= 2; m++) begin
      start(3, 0, m);
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        if (c == 4) begin
          chk("mm_valid", valid, 1);
          chk(m == 1 ? "max_out0" : "min_out0", out0, m == 1 ? 32'd7 : 32'hFFFF_FFFB);
        end
        run = 1'b0;
        if (c <= 3) in0 = mm_vals[c-1];
      end
      go_idle();
    end

    // Sum wrap, then reserved mode 3 acting as sum.
    start(2, 0, 0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 3) chk("wrap_out0", out0, 32'd1);
      run = 1'b0;
      in0 = (c == 1) ? 32'hFFFF_FFFF : 32'd2;
    end
    go_idle();
    start(2, 0, 3);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 3) chk("mode3_out0", out0, 32'd7);
      run = 1'b0;
      in0 = c + 2;
    end
    go_idle();

    // Period 0 acts as 1: out0 follows in0 one cycle later.
    start(0, 0, 1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("p0_valid", valid, (c >= 2) ? 1 : 0);
      if (c >= 2) chk("p0_out0", out0, 32'd100 + c - 1);
      run = 1'b0;
      in0 = 32'd100 + c;
    end
    go_idle();

    // Abort after 2 of 4 samples, then a fresh full window.
    start(4, 0, 0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 5) chk("ab_first", out0, 32'd100);
      if (c > 5) begin
        chk("ab_valid", valid, 0);
        chk("ab_hold", out0, 32'd100);
      end
      run = 1'b0;
      in0 = (c <= 4) ? 32'd10 * c : 32'd50 + c;
      if (c >= 7) running = 1'b0;
    end
    start(4, 0, 0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("ab_re_valid", valid, (c == 5) ? 1 : 0);
      if (c == 5) chk("ab_re_out0", out0, 32'd18);
      run = 1'b0;
      in0 = c + 2;
    end
    go_idle();

    // Run on a closing sample: close completes, then a 3-sample window.
    start(2, 0, 0);
    in0 = 32'd4;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("rc_valid", valid, (c == 3 || c == 6) ? 1 : 0);
      if (c == 3) chk("rc_w0", out0, 32'd8);
      if (c == 6) chk("rc_w1", out0, 32'd12);
      run    = (c == 2);
      period = 10'd3;
    end
    go_idle();

    // Reset during ACCUM.
    start(2, 0, 0);
    in0 = 32'd7;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 3) chk("rs_pre", out0, 32'd14);
      run = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rs_out0", out0, 32'd0);
    chk("rs_valid", valid, 0);
    chk("rs_done", done, 1);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rs_quiet", valid, 0);
      in0 = 32'd20 + c;
    end
    start(1, 0, 0);
    in0 = 32'd33;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("rs_rerun_valid", valid, 1);
    chk("rs_rerun_out0", out0, 32'd33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/window_accum.md
# window_accum

Downstream consumer of the delay buffer unit in the Versat datapath. It takes a data stream that has already been aligned by the buffer and reduces it over fixed-length windows: sum, signed max or signed min of `period` consecutive samples. After a configurable start delay, it emits one registered result per window. Windows run back-to-back with no bubble.

## Interface
- `DATA_W`, default 32: sample and result width.
- `PERIOD_W`, default 10: width of the window-length config.
- `DELAY_W`, default 7: width of the start-delay config.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `run`  in  1  start pulse; honoured only when `running`=1 in the same cycle.
- `running`  in  1  accelerator run active; low forces IDLE.
- `in0`  in  DATA_W  input sample, normally the buffer's out0.
- `out0`  out  DATA_W  registered window result (versat_latency = 1).
- `valid`  out  1  one-cycle pulse marking a new `out0`.
- `done`  out  1  high except while in WAIT.
- `period`  in  PERIOD_W  window length in samples; 0 is treated as 1.
- `delay`  in  DELAY_W  cycles to skip after `run` before the first sample.
- `mode`  in  2  reduction: 0 = sum (wraps mod 2^DATA_W), 1 = signed max, 2 = signed min, 3 = reserved (behaves as 0).

## Operation
- **Config latch.** `run`&`running` latches `period`, `delay` and `mode` into shadow registers. Config changes mid-run have no effect.
- **State machine.**
  - IDLE → WAIT on accepted `run` with latched delay>0.
  - IDLE → ACCUM on accepted `run` with delay=0.
  - WAIT decrements the delay counter each cycle and goes to ACCUM on the cycle its count hits 1.
  - ACCUM loops on itself.
  - Any state → IDLE on the edge after a cycle with `running`=0.
  - `run` accepted in WAIT/ACCUM restarts the sequence: re-latch config, clear the accumulator and sample counter.
- **Sampling.** Every ACCUM cycle consumes `in0`. The first sample of a window loads the accumulator directly; it is not combined with the stale value. A sample counter runs 0..period-1.
- **Window close.** On the last sample (counter = period-1):
  - `out0` ← reduce(acc, `in0`);
  - `valid`=1 for the next cycle;
  - counter ← 0;
  - the following sample starts a new window.
- **Arithmetic.** Sums truncate to DATA_W. Max/min compare as two's complement. On ties, the earlier value is kept (values are equal either way).
- **Abort.** Leaving ACCUM through `running`=0 discards any partial window. No `valid` is produced, `out0` holds its last value, and the accumulator is cleared.
- **Reset.** `rst` beats `run` and `running`. Reset state: state IDLE, `out0`=0, `valid`=0, `done`=1, accumulator and counters 0, shadow period=1, delay=0, mode=0.

## Timing
- Let cycle t0 be the cycle where `run` is accepted.
- The first sample is `in0` at cycle t0+1+delay.
- Window k covers samples t0+1+delay+k·P through t0+delay+(k+1)·P, where P = max(period,1).
- The result of window k is visible on `out0` with `valid`=1 in cycle t0+1+delay+(k+1)·P.
- P=1: `out0` = `in0` delayed by one cycle, and `valid` is high every ACCUM cycle.
- `done`=0 exactly during cycles t0+1 .. t0+delay.
- A `run` in the same cycle as a window close still updates `out0`/`valid` for the closing window, then restarts.
- A result emitted at the edge where `running` falls remains valid; windows not yet closed are dropped.

## Test plan
- **Sum, no delay.** mode=0, period=4, delay=0, `in0` = 1,2,3,... from t0+1.
  - t0+5: `out0`=10, `valid`=1.
  - t0+9: `out0`=26.
  - `valid`=0 at all other cycles.
- **Start delay.** delay=3, period=2, `in0` = 5 every cycle.
  - `done`=0 for t0+1..t0+3.
  - First `valid` at t0+6 with `out0`=10.
- **Signed max/min.** mode=1, period=3, `in0` = -5, 7, -1: `out0`=7. Repeat with mode=2: `out0`=-5 (0xFFFFFFFB).
- **Wrap and P=1 corners.**
  - Sum wrap: `in0` = 0xFFFFFFFF, 2 with period=2 gives `out0`=1.
  - period=0: `out0` follows `in0` with 1-cycle latency and `valid` high every cycle.
- **Abort.** Drop `running` after 2 of 4 samples: no `valid`, `out0` retains its previous result. A fresh `run` then yields a correct full-window sum.
- **Reset mid-run.** Assert `rst` during ACCUM: next cycle `out0`=0, `valid`=0, `done`=1, and further `in0` activity produces no `valid` until a new `run`.
